pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives write enables and bubble-insert
//  (flush) strobes for the PC, F/D, D/X, X/M and M/W latches. Resolves load-use hazards,

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/hazard_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encodings and
// architectural constants.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in D/X and the consumer in F/D.
// Purely combinational; writes to r0 never stall.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic       fd_uses_rt,
    input  logic [4:0] dx_rd,
    input  logic       dx_is_load,
    output logic       load_use_stall
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (dx_rd == fd_rs);
    assign rt_hit = fd_uses_rt && (dx_rd == fd_rt);

    assign load_use_stall = dx_is_load && (dx_rd != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, redirects
// and mult/div occupancy of X. Define PIPE_PERF_EN to add the stall_count port.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
`ifdef PIPE_PERF_EN
    ,
    parameter int PERF_W     = 32
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic       fd_uses_rt,
    input  logic [4:0] dx_rd,
    input  logic       dx_is_load,
    input  logic       dx_is_md,
    input  logic       x_redirect,
    input  logic       md_ready,
    output logic       pc_wren,
    output logic       fd_wren,
    output logic       dx_wren,
    output logic       xm_wren,
    output logic       mw_wren,
    output logic       fd_flush,
    output logic       dx_flush,
    output logic       xm_flush,
    output logic       md_start,
    output logic       md_result_sel,
    output logic       md_error
`ifdef PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] busy_cnt, cnt_nxt;
    logic             err_nxt;
    logic             load_use_stall;

    hazard_detect u_hazard_detect (
        .fd_rs          (fd_rs),
        .fd_rt          (fd_rt),
        .fd_uses_rt     (fd_uses_rt),
        .dx_rd          (dx_rd),
        .dx_is_load     (dx_is_load),
        .load_use_stall (load_use_stall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy_cnt <= '0;
            md_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= cnt_nxt;
            md_error <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = busy_cnt;
        err_nxt       = md_error;
        pc_wren       = 1'b1;
        fd_wren       = 1'b1;
        dx_wren       = 1'b1;
        xm_wren       = 1'b1;
        mw_wren       = 1'b1;
        fd_flush      = 1'b0;
        dx_flush      = 1'b0;
        xm_flush      = 1'b0;
        md_start      = 1'b0;
        md_result_sel = 1'b0;

        case (state)
            IDLE: begin
                if (x_redirect) begin
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                end else if (dx_is_md) begin
                    md_start  = 1'b1;
                    pc_wren   = 1'b0;
                    fd_wren   = 1'b0;
                    dx_wren   = 1'b0;
                    xm_wren   = 1'b0;
                    xm_flush  = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = '0;
                end else if (load_use_stall) begin
                    pc_wren  = 1'b0;
                    fd_wren  = 1'b0;
                    dx_flush = 1'b1;
                end
            end

            // Front of the pipe is frozen while the unit works; redirects
            // cannot occur here because the md instr occupies X.
            BUSY: begin
                pc_wren  = 1'b0;
                fd_wren  = 1'b0;
                dx_wren  = 1'b0;
                xm_wren  = 1'b0;
                xm_flush = 1'b1;
                cnt_nxt  = busy_cnt + 1'b1;
                if (md_ready) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b0;
                end else if (busy_cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
            end

            // The md instr advances out of D/X now, so the F/D instr moving
            // into D/X still needs its own load-use check.
            DONE: begin
                md_result_sel = 1'b1;
                state_nxt     = IDLE;
                err_nxt       = 1'b0;
                if (load_use_stall) begin
                    pc_wren  = 1'b0;
                    fd_wren  = 1'b0;
                    dx_flush = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef PIPE_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!pc_wren && (stall_count != {PERF_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a cycle-level behavioural model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_pipeline_hazard_ctrl;

    localparam int MD_TIMEOUT = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] fd_rs = '0, fd_rt = '0, dx_rd = '0;
    logic       fd_uses_rt = 1'b0, dx_is_load = 1'b0, dx_is_md = 1'b0;
    logic       x_redirect = 1'b0, md_ready = 1'b0;
    logic       pc_wren, fd_wren, dx_wren, xm_wren, mw_wren;
    logic       fd_flush, dx_flush, xm_flush, md_start, md_result_sel, md_error;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(6)) dut (
        .clock(clock), .reset(reset),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt),
        .dx_rd(dx_rd), .dx_is_load(dx_is_load), .dx_is_md(dx_is_md),
        .x_redirect(x_redirect), .md_ready(md_ready),
        .pc_wren(pc_wren), .fd_wren(fd_wren), .dx_wren(dx_wren),
        .xm_wren(xm_wren), .mw_wren(mw_wren),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
        .md_start(md_start), .md_result_sel(md_result_sel), .md_error(md_error)
`ifdef PIPE_PERF_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_md: an md op is occupying X; m_busy: BUSY cycles seen so far;
    // m_done: the cycle the result is handed to X/M.
    bit      mdl_ok = 1'b0;
    bit      m_md = 1'b0, m_done = 1'b0, m_err = 1'b0;
    int      m_busy = 0;
    longint  m_stall = 0;
    logic    e_pc, e_fd, e_dx, e_xm, e_mw, e_fdf, e_dxf, e_xmf, e_st, e_sel, e_err;

    function automatic bit lu();
        return dx_is_load && dx_rd != 0 &&
               (dx_rd == fd_rs || (fd_uses_rt && dx_rd == fd_rt));
    endfunction

    always @(negedge clock) begin
        if (mdl_ok) begin
            {e_pc, e_fd, e_dx, e_xm, e_mw} = 5'b11111;
            {e_fdf, e_dxf, e_xmf, e_st, e_sel, e_err} = 6'b0;
            if (m_done) begin
                e_sel = 1'b1;
                e_err = m_err;
                if (lu()) begin e_pc = 0; e_fd = 0; e_dxf = 1; end
            end else if (m_md) begin
                {e_pc, e_fd, e_dx, e_xm} = 4'b0;
                e_xmf = 1'b1;
            end else if (x_redirect) begin
                e_fdf = 1; e_dxf = 1;
            end else if (dx_is_md) begin
                {e_pc, e_fd, e_dx, e_xm} = 4'b0;
                e_xmf = 1; e_st = 1;
            end else if (lu()) begin
                e_pc = 0; e_fd = 0; e_dxf = 1;
            end
            chk("m_pc_wren", pc_wren, e_pc);
            chk("m_fd_wren", fd_wren, e_fd);
            chk("m_dx_wren", dx_wren, e_dx);
            chk("m_xm_wren", xm_wren, e_xm);
            chk("m_mw_wren", mw_wren, e_mw);
            chk("m_fd_flush", fd_flush, e_fdf);
            chk("m_dx_flush", dx_flush, e_dxf);
            chk("m_xm_flush", xm_flush, e_xmf);
            chk("m_md_start", md_start, e_st);
            chk("m_result_sel", md_result_sel, e_sel);
            chk("m_md_error", md_error, e_err);
`ifdef PIPE_PERF_EN
            chk("m_stall_count", stall_count, 32'(m_stall));
`endif
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            mdl_ok  <= 1'b1;
            m_md    <= 1'b0;
            m_done  <= 1'b0;
            m_err   <= 1'b0;
            m_busy  <= 0;
            m_stall <= 0;
        end else if (mdl_ok) begin
            if (e_pc == 1'b0) m_stall <= m_stall + 1;
            if (m_done) begin
                m_done <= 1'b0;
                m_err  <= 1'b0;
            end else if (m_md) begin
                m_busy <= m_busy + 1;
                if (md_ready) begin
                    m_md <= 1'b0; m_done <= 1'b1; m_err <= 1'b0;
                end else if (m_busy + 1 == MD_TIMEOUT) begin
                    m_md <= 1'b0; m_done <= 1'b1; m_err <= 1'b1;
                end
            end else if (!x_redirect && dx_is_md) begin
                m_md   <= 1'b1;
                m_busy <= 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic look();
        @(negedge clock); #1;
    endtask

    task automatic clear_in();
        fd_rs = 0; fd_rt = 0; fd_uses_rt = 0; dx_rd = 0;
        dx_is_load = 0; dx_is_md = 0; x_redirect = 0; md_ready = 0;
    endtask

    // Runs one md op from its start cycle to the DONE cycle; ready_at=0 means
    // the unit never answers. Returns BUSY cycles seen and md_error in DONE.
    task automatic run_md(input int ready_at, output int busy, output logic err);
        bit seen = 0;
        int k = 0;
        busy = 0;
        err  = 1'bx;
        dx_is_md = 1;
        look();
        chk("md_start_pulse", md_start, 1);
        tick();
        while (!seen && k < 60) begin
            k++;
            md_ready = (ready_at != 0 && k == ready_at);
            x_redirect = (k == 5);
            look();
            if (md_result_sel) begin
                seen = 1;
                err  = md_error;
                chk("done_pc_wren", pc_wren, 1);
                chk("done_no_start", md_start, 0);
            end else if (xm_flush) begin
                busy++;
            end
            tick();
            md_ready = 0;
            x_redirect = 0;
        end
        if (!seen) chk("done_reached", 0, 1);
        dx_is_md = 0;
    endtask

    int   busy;
    logic err;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        reset = 1;
        tick(); tick();
        reset = 0;
        look();
        chk("rst_pc_wren", pc_wren, 1);
        chk("rst_md_start", md_start, 0);
        chk("rst_md_error", md_error, 0);
        chk("rst_result_sel", md_result_sel, 0);
        chk("rst_xm_flush", xm_flush, 0);
        tick();

        // 1: lw r3 ; add r4,r3,r1 -> one bubble
        dx_is_load = 1; dx_rd = 3; fd_rs = 3; fd_rt = 1; fd_uses_rt = 1;
        look();
        chk("lu_pc_wren", pc_wren, 0);
        chk("lu_fd_wren", fd_wren, 0);
        chk("lu_dx_flush", dx_flush, 1);
        chk("lu_xm_wren", xm_wren, 1);
        tick();
        dx_is_load = 0; dx_rd = 0;
        look();
        chk("lu_resume", pc_wren, 1);
        tick();

        // rt operand match, then same regs but rt not read
        dx_is_load = 1; dx_rd = 5; fd_rs = 2; fd_rt = 5; fd_uses_rt = 1;
        look();
        chk("lu_rt_stall", pc_wren, 0);
        tick();
        fd_uses_rt = 0;
        look();
        chk("lu_rt_unused", pc_wren, 1);
        tick();

        // 2: load to r0 never stalls
        clear_in();
        dx_is_load = 1; dx_rd = 0; fd_rs = 0; fd_rt = 0; fd_uses_rt = 1;
        look();
        chk("r0_pc_wren", pc_wren, 1);
        chk("r0_dx_flush", dx_flush, 0);
        tick();

        // 5: redirect beats load-use
        clear_in();
        dx_is_load = 1; dx_rd = 7; fd_rs = 7; x_redirect = 1;
        look();
        chk("redir_fd_flush", fd_flush, 1);
        chk("redir_dx_flush", dx_flush, 1);
        chk("redir_pc_wren", pc_wren, 1);
        tick();
        clear_in();

        // 3: mult answered 32 cycles after start
        run_md(32, busy, err);
        chk("mult_busy_cycles", busy, 32);
        chk("mult_md_error", err, 0);
        look();
        chk("mult_idle_after", pc_wren, 1);
        chk("mult_err_clear", md_error, 0);
        tick();

        // 4: div never answers -> timeout
        run_md(0, busy, err);
        chk("div_busy_cycles", busy, 40);
        chk("div_md_error", err, 1);
        look();
        chk("div_err_clear", md_error, 0);
        tick();

        // ready on the timeout cycle is a success
        run_md(40, busy, err);
        chk("edge_busy_cycles", busy, 40);
        chk("edge_md_error", err, 0);

        // load-use evaluated during DONE against the advancing F/D instr
        dx_is_md = 1;
        tick();
        for (int k = 1; k <= 3; k++) begin
            md_ready = (k == 3);
            tick();
        end
        md_ready = 0;
        dx_is_load = 1; dx_rd = 9; fd_rs = 9;
        look();
        chk("done_lu_sel", md_result_sel, 1);
        chk("done_lu_pc", pc_wren, 0);
        tick();
        clear_in();
        tick();

        // 6: reset during BUSY cycle 10
        dx_is_md = 1;
        tick();
        for (int k = 1; k <= 9; k++) tick();
        reset = 1;
        tick();
        reset = 0;
        dx_is_md = 0;
        look();
        chk("rst_busy_pc_wren", pc_wren, 1);
        chk("rst_busy_xm_flush", xm_flush, 0);
`ifdef PIPE_PERF_EN
        chk("rst_busy_stall_cnt", stall_count, 0);
`endif
        tick();
        md_ready = 1;
        tick();
        md_ready = 0;
        look();
        chk("late_ready_ignored", md_result_sel, 0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
